// File: rtl/ece453_avalon_pkg.sv
// Shared definitions for the ece453 Avalon-MM initiator: FSM encoding, default
// bus widths and the register map of the ece453 slave peripherals.
package ece453_avalon_pkg;

  localparam int DEFAULT_ADDR_W = 5;
  localparam int DEFAULT_DATA_W = 32;
  localparam int LAT_W          = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  localparam logic [DEFAULT_ADDR_W-1:0] REG_DEV_ID   = 5'd0;
  localparam logic [DEFAULT_ADDR_W-1:0] REG_CONTROL  = 5'd1;
  localparam logic [DEFAULT_ADDR_W-1:0] REG_STATUS   = 5'd2;
  localparam logic [DEFAULT_ADDR_W-1:0] REG_IM       = 5'd3;
  localparam logic [DEFAULT_ADDR_W-1:0] REG_IRQ      = 5'd4;
  localparam logic [DEFAULT_ADDR_W-1:0] REG_GPIO_IN  = 5'd5;
  localparam logic [DEFAULT_ADDR_W-1:0] REG_GPIO_OUT = 5'd6;

endpackage

// File: rtl/ece453_avalon_timeout.sv
// Stall watchdog: counts waitrequest cycles and flags the cycle on which the
// count reaches TIMEOUT. TIMEOUT = 0 never expires.
module ece453_avalon_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The edge that would take the count to TIMEOUT is the expiry edge.
  assign expire_o = (TIMEOUT != 0) && stall_i && (cnt_q == LIMIT);

  // Next-state for the stall counter
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (stall_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ece453_avalon_master.sv
// ece453_avalon_master: single-outstanding Avalon-MM initiator with a
// valid/ready command channel and a valid/ready response channel.
module ece453_avalon_master
  import ece453_avalon_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_byteenable,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic [ADDR_W-1:0]   master_address,
  output logic                master_read,
  output logic                master_write,
  output logic [DATA_W-1:0]   master_writedata,
  output logic [DATA_W/8-1:0] master_byteenable,
  input  logic [DATA_W-1:0]   master_readdata,
  input  logic                master_waitrequest,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [LAT_W-1:0] LAT_LOAD =
      (READ_LATENCY > 0) ? LAT_W'(READ_LATENCY - 1) : '0;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [BE_W-1:0]    be_q, be_d;
  logic               read_q, read_d;
  logic               write_q, write_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_error_q, rsp_error_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               cmd_ready_q;
  logic               busy_q;
  logic               stall_s;
  logic               clear_s;
  logic               expire_s;

  assign stall_s = (state_q == ST_ISSUE) && master_waitrequest;
  assign clear_s = (state_d != ST_ISSUE);

  ece453_avalon_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (reset),
    .stall_i  (stall_s),
    .clear_i  (clear_s),
    .expire_o (expire_s)
  );

  // Transaction FSM: next state, bus fields and response fields
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    read_d      = read_q;
    write_d     = write_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    lat_d       = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          be_d    = cmd_byteenable;
          write_d = cmd_write;
          read_d  = ~cmd_write;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A slave accept on the expiry edge wins over the timeout.
        if (!master_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            rsp_rdata_d = '0;
            rsp_error_d = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else if (READ_LATENCY == 0) begin
            rsp_rdata_d = master_readdata;
            rsp_error_d = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end else begin
            lat_d   = LAT_LOAD;
            state_d = ST_RD_WAIT;
          end
        end else if (expire_s) begin
          read_d      = 1'b0;
          write_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_error_d = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RD_WAIT: begin
        if (lat_q == '0) begin
          rsp_rdata_d = master_readdata;
          rsp_error_d = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          lat_d   = lat_q - LAT_W'(1);
          state_d = ST_RD_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        read_d      = 1'b0;
        write_d     = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, bus and response registers; status flags follow the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      lat_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      read_q      <= read_d;
      write_q     <= write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      lat_q       <= lat_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign cmd_ready         = cmd_ready_q;
  assign busy              = busy_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_error         = rsp_error_q;
  assign master_address    = addr_q;
  assign master_read       = read_q;
  assign master_write      = write_q;
  assign master_writedata  = wdata_q;
  assign master_byteenable = be_q;

endmodule
